// File: rtl/counter_pkg.sv
// Shared constants for the up/down counter: boundary mode and count direction.
// Pure constants; no logic, no latency, no flow control.
package counter_pkg;

  localparam logic MODE_WRAP = 1'b0;
  localparam logic MODE_SAT  = 1'b1;

  localparam logic DIR_UP    = 1'b1;
  localparam logic DIR_DOWN  = 1'b0;

endpackage

// File: rtl/counter_next.sv
// Next-count and boundary-event logic for one enabled step of the counter.
// Purely combinational (zero latency); no backpressure.
module counter_next
  import counter_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic [WIDTH-1:0] count,
  input  logic [WIDTH-1:0] limit,
  input  logic             updown,
  input  logic             mode,
  output logic [WIDTH-1:0] nxt,
  output logic             up_evt,
  output logic             dn_evt
);

  always_comb begin
    nxt    = count;
    up_evt = 1'b0;
    dn_evt = 1'b0;
    if (updown == DIR_UP) begin
      if (count >= limit) begin
        up_evt = 1'b1;
        nxt    = (mode == MODE_SAT) ? limit : '0;
      end else begin
        nxt = count + WIDTH'(1);
      end
    end else begin
      // Zero is tested first: a count above a lowered limit is never zero.
      if (count == '0) begin
        dn_evt = 1'b1;
        nxt    = (mode == MODE_SAT) ? '0 : limit;
      end else if (count > limit) begin
        nxt = limit;
      end else begin
        nxt = count - WIDTH'(1);
      end
    end
  end

endmodule

// File: rtl/counter_updown_mod.sv
// Up/down modulo counter with load, wrap/saturate bounds, tc pulse and sticky ovf/unf.
// Latency 1 clk from any input to outputs; no backpressure, every enabled edge steps.
module counter_updown_mod
  import counter_pkg::*;
#(
  parameter int WIDTH    = 8,
  parameter int SATURATE = 0
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             enable,
  input  logic             load,
  input  logic [WIDTH-1:0] data,
  input  logic             updown,
  input  logic [WIDTH-1:0] limit,
  input  logic             clr_flags,
  output logic [WIDTH-1:0] count,
  output logic             tc,
  output logic             ovf,
  output logic             unf
);

  localparam logic MODE = (SATURATE != 0) ? MODE_SAT : MODE_WRAP;

  logic [WIDTH-1:0] nxt;
  logic             up_evt;
  logic             dn_evt;
  logic             step;
  logic [WIDTH-1:0] load_val;

  counter_next #(
    .WIDTH (WIDTH)
  ) u_next (
    .count  (count),
    .limit  (limit),
    .updown (updown),
    .mode   (MODE),
    .nxt    (nxt),
    .up_evt (up_evt),
    .dn_evt (dn_evt)
  );

  assign step     = enable & ~load;
  assign load_val = (data > limit) ? limit : data;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      count <= '0;
      tc    <= 1'b0;
      ovf   <= 1'b0;
      unf   <= 1'b0;
    end else begin
      if (load) begin
        count <= load_val;
      end else if (enable) begin
        count <= nxt;
      end
      tc  <= step & (up_evt | dn_evt);
      // A new event in the same cycle as clr_flags leaves the flag set.
      ovf <= (ovf & ~clr_flags) | (step & up_evt);
      unf <= (unf & ~clr_flags) | (step & dn_evt);
    end
  end

endmodule

// File: tb/tb_counter_updown_mod.sv
// Directed bench for counter_updown_mod at WIDTH=4, wrap and saturate instances side by side.
module tb_counter_updown_mod;

  logic       clk = 1'b0;
  logic       reset;
  logic       enable;
  logic       load;
  logic [3:0] data;
  logic       updown;
  logic [3:0] limit;
  logic       clr_flags;

  logic [3:0] w_count, s_count;
  logic       w_tc, w_ovf, w_unf;
  logic       s_tc, s_ovf, s_unf;

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  counter_updown_mod #(.WIDTH(4), .SATURATE(0)) u_wrap (
    .clk       (clk),
    .reset     (reset),
    .enable    (enable),
    .load      (load),
    .data      (data),
    .updown    (updown),
    .limit     (limit),
    .clr_flags (clr_flags),
    .count     (w_count),
    .tc        (w_tc),
    .ovf       (w_ovf),
    .unf       (w_unf)
  );

  counter_updown_mod #(.WIDTH(4), .SATURATE(1)) u_sat (
    .clk       (clk),
    .reset     (reset),
    .enable    (enable),
    .load      (load),
    .data      (data),
    .updown    (updown),
    .limit     (limit),
    .clr_flags (clr_flags),
    .count     (s_count),
    .tc        (s_tc),
    .ovf       (s_ovf),
    .unf       (s_unf)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Advance one edge and settle just after it; inputs change only here.
  task automatic step_clk();
    @(posedge clk);
    #1;
  endtask

  initial begin
    reset     = 1'b1;
    enable    = 1'b0;
    load      = 1'b0;
    data      = 4'd0;
    updown    = 1'b1;
    limit     = 4'd9;
    clr_flags = 1'b0;
    #2;
    check("rst_w_count", 32'(w_count), 0);
    check("rst_w_tc",    32'(w_tc),    0);
    check("rst_w_ovf",   32'(w_ovf),   0);
    check("rst_s_unf",   32'(s_unf),   0);
    @(negedge clk);
    reset = 1'b0;

    // Wrap up-count 0 -> 1..9, 0, 1, 2 with tc on the 9->0 step.
    enable = 1'b1;
    updown = 1'b1;
    for (int i = 1; i <= 12; i++) begin
      step_clk();
      check("up_wrap_count", 32'(w_count), (i <= 9) ? i : i - 10);
      check("up_wrap_tc",    32'(w_tc),    (i == 10) ? 1 : 0);
    end
    check("up_wrap_ovf", 32'(w_ovf), 1);
    check("up_wrap_unf", 32'(w_unf), 0);
    check("up_sat_hold", 32'(s_count), 9);

    // Saturating down-count from a load of 7.
    enable = 1'b0;
    load   = 1'b1;
    data   = 4'd7;
    step_clk();
    check("load7_sat", 32'(s_count), 7);
    load   = 1'b0;
    enable = 1'b1;
    updown = 1'b0;
    for (int i = 1; i <= 9; i++) begin
      step_clk();
      check("dn_sat_count", 32'(s_count), (i <= 7) ? 7 - i : 0);
      check("dn_sat_tc",    32'(s_tc),    (i >= 8) ? 1 : 0);
    end
    check("dn_sat_unf",   32'(s_unf),   1);
    check("dn_wrap_count", 32'(w_count), 8);
    check("dn_wrap_unf",  32'(w_unf),   1);

    // Load clamps to limit, and load beats a same-cycle step.
    enable = 1'b0;
    load   = 1'b1;
    data   = 4'd12;
    step_clk();
    check("load_clamp", 32'(w_count), 9);
    data   = 4'd3;
    enable = 1'b1;
    updown = 1'b1;
    step_clk();
    check("load_wins_count", 32'(w_count), 3);
    check("load_wins_tc",    32'(w_tc),    0);

    // Limit lowered below count: down step snaps to limit, no event.
    enable = 1'b0;
    data   = 4'd8;
    step_clk();
    check("load8", 32'(w_count), 8);
    load   = 1'b0;
    limit  = 4'd5;
    enable = 1'b1;
    updown = 1'b0;
    step_clk();
    check("lowered_count", 32'(w_count), 5);
    check("lowered_tc",    32'(w_tc),    0);
    updown = 1'b1;
    step_clk();
    check("lowered_wrap_count", 32'(w_count), 0);
    check("lowered_wrap_tc",    32'(w_tc),    1);

    // clr_flags racing a new up event: set wins; clr alone clears.
    enable = 1'b0;
    load   = 1'b1;
    data   = 4'd5;
    step_clk();
    load      = 1'b0;
    enable    = 1'b1;
    clr_flags = 1'b1;
    step_clk();
    check("clr_race_ovf", 32'(w_ovf), 1);
    check("clr_race_tc",  32'(w_tc),  1);
    check("clr_race_unf", 32'(w_unf), 0);
    enable = 1'b0;
    step_clk();
    check("clr_alone_ovf", 32'(w_ovf), 0);
    check("clr_alone_tc",  32'(w_tc),  0);
    clr_flags = 1'b0;

    // limit = 0: every enabled step is a boundary event.
    limit  = 4'd0;
    enable = 1'b1;
    updown = 1'b1;
    step_clk();
    check("lim0_up_count", 32'(w_count), 0);
    check("lim0_up_tc",    32'(w_tc),    1);
    check("lim0_up_ovf",   32'(w_ovf),   1);
    updown = 1'b0;
    step_clk();
    check("lim0_dn_count", 32'(w_count), 0);
    check("lim0_dn_tc",    32'(w_tc),    1);
    check("lim0_dn_unf",   32'(w_unf),   1);

    // limit all-ones behaves as a full binary counter.
    limit  = 4'd15;
    enable = 1'b0;
    load   = 1'b1;
    data   = 4'd15;
    step_clk();
    check("full_load", 32'(w_count), 15);
    load   = 1'b0;
    enable = 1'b1;
    updown = 1'b1;
    step_clk();
    check("full_wrap_count", 32'(w_count), 0);
    check("full_wrap_tc",    32'(w_tc),    1);
    step_clk();
    check("full_next", 32'(w_count), 1);

    // Asynchronous reset between edges at count 6.
    limit  = 4'd9;
    enable = 1'b0;
    load   = 1'b1;
    data   = 4'd0;
    step_clk();
    load   = 1'b0;
    enable = 1'b1;
    for (int i = 1; i <= 6; i++) step_clk();
    check("pre_rst_count", 32'(w_count), 6);
    #1;
    reset = 1'b1;
    #1;
    check("arst_count", 32'(w_count), 0);
    check("arst_tc",    32'(w_tc),    0);
    check("arst_ovf",   32'(w_ovf),   0);
    check("arst_unf",   32'(w_unf),   0);
    check("arst_s_ovf", 32'(s_ovf),   0);
    @(negedge clk);
    reset = 1'b0;
    step_clk();
    check("post_rst_count", 32'(w_count), 1);
    check("post_rst_tc",    32'(w_tc),    0);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
